// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-port arbiter/sequencer that serialises requests onto one SRAM port.
// Ports: clk/rst, reqN/rwN/addrN/dinN in, ackN/rdataN/rvalidN out, mem_* SRAM side.
// Macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins); default is round-robin.
module sram_rr_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RDATA
  } state_t;

  state_t          r_state;
  logic            r_last;
  logic            r_win;
  logic            r_ack0;
  logic            r_ack1;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;
  logic            r_mem_en;
  logic            r_mem_rw;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_din;

  logic            w_pick1;
  logic            w_rw;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_din;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Port 0 always wins; r_last is tracked but does not steer the choice.
  assign w_pick1 = req1 & ~req0;
`else
  // On a tie, serve the port that was not granted last.
  assign w_pick1 = req1 & (~req0 | ~r_last);
`endif

  assign w_rw   = w_pick1 ? rw1   : rw0;
  assign w_addr = w_pick1 ? addr1 : addr0;
  assign w_din  = w_pick1 ? din1  : din0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_mem_en   <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_state    <= S_ISSUE;
            r_win      <= w_pick1;
            r_last     <= w_pick1;
            r_ack0     <= ~w_pick1;
            r_ack1     <= w_pick1;
            r_mem_en   <= 1'b1;
            r_mem_rw   <= w_rw;
            r_mem_addr <= w_addr;
            r_mem_din  <= w_din;
          end
        end
        S_ISSUE: begin
          if (r_mem_rw) begin
            // Write lands at the SRAM on this edge.
            r_state    <= S_IDLE;
            r_mem_en   <= 1'b0;
            r_mem_rw   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
          end else begin
            // Hold the read address while the SRAM output settles.
            r_state <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (r_win) begin
            r_rdata1  <= mem_dout;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= mem_dout;
            r_rvalid0 <= 1'b1;
          end
          r_state    <= S_IDLE;
          r_mem_en   <= 1'b0;
          r_mem_rw   <= 1'b0;
          r_mem_addr <= '0;
          r_mem_din  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign mem_en   = r_mem_en;
  assign mem_rw   = r_mem_rw;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: vector table plus directed sequences for sram_rr_arbiter.
// Includes a behavioural SRAM with a one-cycle registered read port.
module tb_sram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rw0, rw1;
  logic [7:0] addr0, addr1, din0, din1;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_rw;
  logic [7:0] mem_addr, mem_din, mem_dout;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sram [256];

  sram_rr_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1),
    .din0(din0), .din1(din1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_rw) sram[mem_addr] <= mem_din;
    if (mem_en && !mem_rw) mem_dout <= sram[mem_addr];
  end

  typedef struct {
    logic       rst, r0, r1, w0, w1;
    logic [7:0] a0, a1, d0, d1;
    logic       k0, k1, v0, v1;
    logic [7:0] rd0, rd1;
    logic       en, rw;
    logic [7:0] ma, md;
  } vec_t;

  function automatic vec_t mk(
    input logic rs, r0, r1, w0, w1,
    input logic [7:0] a0, a1, d0, d1,
    input logic k0, k1, v0, v1,
    input logic [7:0] rd0, rd1,
    input logic en, rw,
    input logic [7:0] ma, md);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.k0 = k0; v.k1 = k1; v.v0 = v0; v.v1 = v1;
    v.rd0 = rd0; v.rd1 = rd1; v.en = en; v.rw = rw;
    v.ma = ma; v.md = md;
    return v;
  endfunction

  function automatic logic [37:0] outs();
    return {ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
            mem_en, mem_rw, mem_addr, mem_din};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = 0; addr1 = 0; din0 = 0; din1 = 0;
  endtask

  vec_t vt [14];

  initial begin
    int g;
    int seen;
    int exp_w;
    int na;
    for (int i = 0; i < 256; i++) sram[i] = 8'h00;
    sram[1] = 8'h11;
    sram[2] = 8'h22;
    mem_dout = 8'h00;
    idle_in();

    //       rs r0 r1 w0 w1 a0     a1     d0     d1    k0 k1 v0 v1 rd0    rd1   en rw ma     md
    vt[0]  = mk(1,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h00,8'h00);
    vt[1]  = mk(0,1,0,1,0,8'h05,8'h00,8'hA5,8'h00, 1,0,0,0,8'h00,8'h00,1,1,8'h05,8'hA5);
    vt[2]  = mk(0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h00,8'h00);
    vt[3]  = mk(0,1,0,0,0,8'h05,8'h00,8'h00,8'h00, 1,0,0,0,8'h00,8'h00,1,0,8'h05,8'h00);
    vt[4]  = mk(0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,1,0,8'h05,8'h00);
    vt[5]  = mk(0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,1,0,8'hA5,8'h00,0,0,8'h00,8'h00);
    vt[6]  = mk(0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,8'hA5,8'h00,0,0,8'h00,8'h00);
    vt[7]  = mk(1,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h00,8'h00);
    vt[8]  = mk(0,1,1,0,0,8'h01,8'h02,8'h00,8'h00, 1,0,0,0,8'h00,8'h00,1,0,8'h01,8'h00);
    vt[9]  = mk(0,0,1,0,0,8'h00,8'h02,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,1,0,8'h01,8'h00);
    vt[10] = mk(0,0,1,0,0,8'h00,8'h02,8'h00,8'h00, 0,0,1,0,8'h11,8'h00,0,0,8'h00,8'h00);
    vt[11] = mk(0,0,1,0,0,8'h00,8'h02,8'h00,8'h00, 0,1,0,0,8'h11,8'h00,1,0,8'h02,8'h00);
    vt[12] = mk(0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,0,8'h11,8'h00,1,0,8'h02,8'h00);
    vt[13] = mk(0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,1,8'h11,8'h22,0,0,8'h00,8'h00);

    #2;
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; req0 = vt[i].r0; req1 = vt[i].r1;
      rw0 = vt[i].w0; rw1 = vt[i].w1;
      addr0 = vt[i].a0; addr1 = vt[i].a1;
      din0 = vt[i].d0; din1 = vt[i].d1;
      tick();
      chk($sformatf("vec%0d", i), {26'd0, outs()},
          {26'd0, vt[i].k0, vt[i].k1, vt[i].v0, vt[i].v1,
           vt[i].rd0, vt[i].rd1, vt[i].en, vt[i].rw,
           vt[i].ma, vt[i].md});
    end

    // Both ports hold write requests; grants alternate (round-robin).
    idle_in();
    req0 = 1; req1 = 1; rw0 = 1; rw1 = 1;
    addr0 = 8'h10; addr1 = 8'h20; din0 = 8'h30; din1 = 8'h40;
    g = 0;
    for (int c = 0; c < 40 && g < 6; c++) begin
      tick();
      if (ack0 && ack1) chk("t3_overlap", {ack0, ack1}, 2'b00);
      if (ack0 || ack1) begin
        seen = ack1 ? 1 : 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_w = 0;
`else
        exp_w = g % 2;
`endif
        chk($sformatf("t3_grant%0d", g), seen, exp_w);
        g++;
      end
    end
    chk("t3_grant_count", g, 6);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    req0 = 0;
    seen = 0;
    for (int c = 0; c < 6 && seen == 0; c++) begin
      tick();
      if (ack1) seen = 1;
      if (ack0) chk("t6_no_ack0", ack0, 1'b0);
    end
    chk("t6_port1_served", seen, 1);
`endif
    idle_in();
    tick();
    tick();
    chk("t3_sram_p0", sram[8'h10], 8'h30);
    chk("t3_sram_p1", sram[8'h20], 8'h40);

    // Reset during RDATA: read is dropped and arbitration restarts.
    idle_in();
    req0 = 1; rw0 = 0; addr0 = 8'h05;
    tick();
    chk("t4_ack0", {ack0, ack1}, 2'b10);
    req0 = 0;
    tick();
    chk("t4_rdata_state", {mem_en, mem_rw, mem_addr}, {2'b10, 8'h05});
    rst = 1;
    tick();
    chk("t4_rst_outs", {26'd0, outs()}, 64'd0);
    rst = 0;
    tick();
    chk("t4_no_rvalid", {26'd0, outs()}, 64'd0);
    req0 = 1; req1 = 1; rw0 = 0; rw1 = 0;
    addr0 = 8'h05; addr1 = 8'h02;
    tick();
    chk("t4_port0_first", {ack0, ack1}, 2'b10);
    idle_in();
    tick();
    tick();
    chk("t4_read_done", {rvalid0, rvalid1, rdata0}, {2'b10, 8'hA5});

    // Port 1 alone: four back-to-back writes, one every 2 cycles.
    idle_in();
    req1 = 1; rw1 = 1; addr1 = 8'h40; din1 = 8'hC0;
    na = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("t5_ack1_c%0d", c), {ack0, ack1}, {1'b0, (c % 2) == 0});
      chk($sformatf("t5_rw_c%0d", c), mem_rw, (c % 2) == 0);
      if (ack1) begin
        na++;
        addr1 = 8'h40 + 8'(na);
        din1 = 8'hC0 + 8'(na);
        if (na == 4) req1 = 0;
      end
    end
    tick();
    chk("t5_sram", {sram[8'h40], sram[8'h41], sram[8'h42], sram[8'h43]},
        32'hC0C1C2C3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
